// File: rtl/aes_core_scheduler.sv
// Time-shares one non-pipelined mainAES core among NUM_REQ valid/ready requesters.
// Arbitration: fixed priority by default, round-robin when AES_SCHED_RR_EN is defined.
module aes_core_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CORE_LATENCY = 12,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic [127:0]           core_input,
  output logic [127:0]           core_key,
  input  logic [127:0]           core_output,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [127:0]           resp_data,
  output logic [ID_W-1:0]        resp_id
);

  localparam int CNT_W = $clog2(CORE_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ID_W-1:0]   gnt;
  logic              gnt_vld;
  logic              accept;
  logic              done;

`ifdef AES_SCHED_RR_EN
  logic [ID_W-1:0] ptr_q;
  logic [ID_W:0]   idx;

  // Descending scan: the last hit is the valid requester nearest the pointer.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (req_valid[idx[ID_W-1:0]]) begin
        gnt     = idx[ID_W-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);
    end
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt     = ID_W'(k);
        gnt_vld = 1'b1;
      end
    end
  end
`endif

  assign accept = (state_q == S_IDLE) && gnt_vld;
  assign done   = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_BUSY;
      S_BUSY:  if (done) state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_input <= '0;
      core_key   <= '0;
      cnt_q      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else begin
      if (accept) begin
        core_input <= req_data[128*int'(gnt) +: 128];
        core_key   <= req_key[128*int'(gnt) +: 128];
        resp_id    <= gnt;
        cnt_q      <= CNT_W'(CORE_LATENCY);
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (done) begin
        resp_data  <= core_output;
        resp_valid <= 1'b1;
      end else if (state_q == S_RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler with a timing-aware stand-in for the mainAES core.
module tb_aes_core_scheduler;

  localparam int N = 4;
  localparam int L = 12;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*128-1:0] req_data;
  logic [N*128-1:0] req_key;
  logic [127:0]     core_input;
  logic [127:0]     core_key;
  logic [127:0]     core_output = '0;
  logic             resp_valid;
  logic             resp_ready;
  logic [127:0]     resp_data;
  logic [1:0]       resp_id;

  aes_core_scheduler #(.NUM_REQ(N), .CORE_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key),
    .core_input(core_input), .core_key(core_key), .core_output(core_output),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int onehot_bad = 0;
  int acc_q[$];
  int acct_q[$];
  int rid_q[$];
  int rcyc_q[$];
  logic [127:0] rdat_q[$];

  function automatic logic [127:0] enc(input logic [127:0] d, input logic [127:0] k);
    if (d == PT1 && k == KY1) return CT1;
    if (d == PT2 && k == KY2) return CT2;
    return {d[63:0], d[127:64]} ^ k ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic logic [127:0] mk_d(input int i);
    return {32'hA0A0_0000 + 32'(i), 96'h0123_4567_89ab_cdef_0011_2233};
  endfunction

  function automatic logic [127:0] mk_k(input int i);
    return {96'hfeed_face_cafe_beef_1357_9bdf, 32'h0B0B_0000 + 32'(i)};
  endfunction

  // Core stand-in: the true result appears only after the inputs have been stable
  // for L cycles; anything earlier returns a corrupted value.
  logic [255:0] core_prev = '0;
  int           core_stable = 0;
  always @(negedge clk) begin
    if ({core_input, core_key} != core_prev) core_stable = 0;
    else if (core_stable < 1000) core_stable = core_stable + 1;
    core_prev   = {core_input, core_key};
    core_output = (core_stable >= L - 1) ? enc(core_input, core_key) : ~enc(core_input, core_key);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: logs handshakes seen at the edge, then retires accepted requests
  // and scrambles their data so late sampling by the DUT would be visible.
  task automatic step();
    logic [N-1:0] acc;
    logic         rsp;
    int           rid;
    logic [127:0] rdat;
    @(posedge clk);
    acc  = req_valid & req_ready;
    rsp  = resp_valid && resp_ready;
    rid  = int'(resp_id);
    rdat = resp_data;
    if ($countones(req_ready) > 1) onehot_bad++;
    #1;
    cyc++;
    if (rsp) begin
      rid_q.push_back(rid);
      rdat_q.push_back(rdat);
      rcyc_q.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        acc_q.push_back(i);
        acct_q.push_back(cyc);
        req_valid[i] = 1'b0;
        req_data[128*i +: 128] = ~req_data[128*i +: 128];
        req_key[128*i +: 128]  = ~req_key[128*i +: 128];
      end
    end
  endtask

  task automatic set_req(input int i, input logic [127:0] d, input logic [127:0] k);
    req_valid[i] = 1'b1;
    req_data[128*i +: 128] = d;
    req_key[128*i +: 128]  = k;
  endtask

  task automatic clear_logs();
    acc_q.delete(); acct_q.delete();
    rid_q.delete(); rdat_q.delete(); rcyc_q.delete();
  endtask

  task automatic wait_acc(input string tag, input int budget, output int id, output int t);
    int n0 = acc_q.size();
    id = -1;
    t  = 0;
    for (int k = 0; k < budget && acc_q.size() == n0; k++) step();
    if (acc_q.size() == n0) chk({tag, "_timeout"}, 128'(0), 128'(1));
    else begin
      id = acc_q[n0];
      t  = acct_q[n0];
    end
  endtask

  task automatic wait_resp(input string tag, input int budget, output int t);
    int k = 0;
    while (!resp_valid && k < budget) begin
      step();
      k++;
    end
    if (!resp_valid) chk({tag, "_timeout"}, 128'(0), 128'(1));
    t = cyc;
  endtask

  initial begin
    int id, t0, t1, bad, exp_id;
    logic [127:0] hold_d, ci;
    logic [1:0]   hold_id;

    rst_n = 1'b0; req_valid = '0; req_data = '0; req_key = '0; resp_ready = 1'b1;
    repeat (3) step();
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_core_input", core_input, 128'(0));
    chk("rst_core_key", core_key, 128'(0));
    chk("rst_resp_data", resp_data, 128'(0));
    chk("rst_resp_id", 128'(resp_id), 128'(0));
    rst_n = 1'b1;
    step();

    // Single request, FIPS-197 vector
    clear_logs();
    set_req(1, PT1, KY1);
    wait_acc("single_acc", 10, id, t0);
    chk("single_acc_id", 128'(id), 128'(1));
    wait_resp("single_resp", 40, t1);
    chk("single_latency", 128'(t1 - t0), 128'(L));
    chk("single_data", resp_data, CT1);
    chk("single_id", 128'(resp_id), 128'(1));
    repeat (3) step();

    // All four requesters at once
    clear_logs();
    for (int i = 0; i < N; i++) set_req(i, mk_d(i), mk_k(i));
    for (int k = 0; k < 4 * (L + 2) + 10 && rid_q.size() < N; k++) step();
    chk("all_acc_count", 128'(acc_q.size()), 128'(N));
    chk("all_resp_count", 128'(rid_q.size()), 128'(N));
    for (int k = 0; k < acc_q.size(); k++) chk("all_order", 128'(acc_q[k]), 128'(k));
    for (int k = 1; k < acct_q.size(); k++) chk("all_spacing", 128'(acct_q[k] - acct_q[k-1]), 128'(L + 2));
    for (int k = 0; k < rid_q.size(); k++) begin
      chk("all_resp_id", 128'(rid_q[k]), 128'(k));
      chk("all_resp_data", rdat_q[k], enc(mk_d(k), mk_k(k)));
    end
    repeat (2) step();

    // Requester 0 re-asserts while requester 1 waits
    clear_logs();
    set_req(0, mk_d(10), mk_k(10));
    set_req(1, mk_d(11), mk_k(11));
    wait_acc("reserve_a", 10, id, t0);
    chk("reserve_first", 128'(id), 128'(0));
    set_req(0, mk_d(12), mk_k(12));
`ifdef AES_SCHED_RR_EN
    exp_id = 1;
`else
    exp_id = 0;
`endif
    wait_acc("reserve_b", L + 10, id, t0);
    chk("reserve_second", 128'(id), 128'(exp_id));
    wait_acc("reserve_c", L + 10, id, t0);
    chk("reserve_third", 128'(id), 128'(1 - exp_id));
    repeat (L + 4) step();

    // Backpressure with requester 2 pending
    clear_logs();
    resp_ready = 1'b0;
    set_req(3, mk_d(3), mk_k(3));
    wait_acc("bp_acc3", 10, id, t0);
    chk("bp_acc3_id", 128'(id), 128'(3));
    set_req(2, mk_d(2), mk_k(2));
    wait_resp("bp_resp", L + 5, t1);
    hold_d  = resp_data;
    hold_id = resp_id;
    chk("bp_data", hold_d, enc(mk_d(3), mk_k(3)));
    chk("bp_id", 128'(hold_id), 128'(3));
    bad = 0;
    repeat (20) begin
      step();
      if (req_ready != '0 || !resp_valid || resp_data != hold_d || resp_id != hold_id) bad++;
    end
    chk("bp_hold", 128'(bad), 128'(0));
    chk("bp_no_accept", 128'(acc_q.size()), 128'(1));
    resp_ready = 1'b1;
    wait_acc("bp_acc2", 5, id, t0);
    chk("bp_acc2_id", 128'(id), 128'(2));
    chk("bp_resp_logged", 128'(rcyc_q.size()), 128'(1));
    if (rcyc_q.size() > 0) chk("bp_acc2_first_idle", 128'(t0 - rcyc_q[0]), 128'(1));
    repeat (L + 4) step();

    // Core inputs stay put while req_data moves
    clear_logs();
    set_req(0, PT2, KY2);
    wait_acc("stab_acc", 10, id, t0);
    bad = 0;
    for (int k = 0; k < L; k++) begin
      if (core_input != PT2 || core_key != KY2) bad++;
      step();
    end
    chk("stab_core_hold", 128'(bad), 128'(0));
    chk("stab_resp_valid", 128'(resp_valid), 128'(1));
    chk("stab_data", resp_data, CT2);
    repeat (3) step();

    // Reset in the middle of BUSY
    clear_logs();
    set_req(1, mk_d(5), mk_k(5));
    wait_acc("mrst_acc", 10, id, t0);
    repeat (L / 2) step();
    rst_n = 1'b0;
    #1;
    chk("mrst_core_input", core_input, 128'(0));
    chk("mrst_core_key", core_key, 128'(0));
    chk("mrst_resp_valid", 128'(resp_valid), 128'(0));
    chk("mrst_resp_data", resp_data, 128'(0));
    chk("mrst_resp_id", 128'(resp_id), 128'(0));
    chk("mrst_req_ready", 128'(req_ready), 128'(0));
    repeat (2) step();
    rst_n = 1'b1;
    bad = 0;
    repeat (L + 6) begin
      step();
      if (resp_valid) bad++;
    end
    chk("mrst_no_resp", 128'(bad), 128'(0));
    set_req(2, PT1, KY1);
    wait_acc("mrst_next_acc", 10, id, t0);
    chk("mrst_next_id_acc", 128'(id), 128'(2));
    wait_resp("mrst_next_resp", 40, t1);
    chk("mrst_next_latency", 128'(t1 - t0), 128'(L));
    chk("mrst_next_data", resp_data, CT1);
    chk("mrst_next_id", 128'(resp_id), 128'(2));
    repeat (3) step();

    // Idle
    ci  = core_input;
    bad = 0;
    repeat (50) begin
      step();
      if (req_ready != '0 || resp_valid || core_input != ci) bad++;
    end
    chk("idle_quiet", 128'(bad), 128'(0));
    chk("ready_onehot", 128'(onehot_bad), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
